// File: rtl/sfifo.sv
// Single-clock synchronous FIFO with arbitrary depth, exact occupancy count,
// programmable almost-full/almost-empty thresholds, flush and sticky error flags.
module sfifo #(
  parameter int unsigned W      = 32,
  parameter int unsigned N      = 16,
  parameter int unsigned AF_LVL = N - 2,
  parameter int unsigned AE_LVL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic                   pop_data_vld_r,
  output logic                   empty_r,
  output logic                   full_r,
  output logic                   afull_r,
  output logic                   aempty_r,
  output logic [$clog2(N+1)-1:0] count_r,
  output logic                   overflow_r,
  output logic                   underflow_r
);

  localparam int unsigned PW = (N <= 2) ? 1 : $clog2(N);
  localparam int unsigned CW = $clog2(N + 1);

  logic [W-1:0]  mem [N];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          ops_en;
  logic          pop_acc;
  logic          push_acc;
  logic [CW-1:0] count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(N - 1)) ? '0 : p + PW'(1);
  endfunction

  // rst and clear both override push/pop
  assign ops_en   = ~rst & ~clear;
  assign pop_acc  = ops_en & pop & ~empty_r;
  assign push_acc = ops_en & push & (~full_r | pop_acc);

  always_comb begin
    count_d = '0;
    if (ops_en) begin
      count_d = count_r + CW'(push_acc) - CW'(pop_acc);
    end
  end

  // Flags are all derived from the next count, so they are exact one edge later
  always_ff @(posedge clk) begin
    count_r  <= count_d;
    empty_r  <= (count_d == '0);
    full_r   <= (count_d == CW'(N));
    afull_r  <= (count_d >= CW'(AF_LVL));
    aempty_r <= (count_d <= CW'(AE_LVL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr           <= '0;
      rptr           <= '0;
      pop_data       <= '0;
      pop_data_vld_r <= 1'b0;
      overflow_r     <= 1'b0;
      underflow_r    <= 1'b0;
    end else if (clear) begin
      wptr           <= '0;
      rptr           <= '0;
      pop_data_vld_r <= 1'b0;
      overflow_r     <= 1'b0;
      underflow_r    <= 1'b0;
    end else begin
      if (push_acc) begin
        wptr <= ptr_inc(wptr);
      end
      if (pop_acc) begin
        rptr     <= ptr_inc(rptr);
        pop_data <= mem[rptr];
      end
      pop_data_vld_r <= pop_acc;
      overflow_r     <= overflow_r | (push & ~push_acc);
      underflow_r    <= underflow_r | (pop & empty_r);
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wptr] <= push_data;
    end
  end

endmodule

// File: tb/tb_sfifo.sv
// Directed bench for sfifo (N=5, W=8): a reference model predicts acceptance,
// flags and errors; a scoreboard queue checks read data order.
module tb_sfifo;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 5;
  localparam int unsigned AF = 3;
  localparam int unsigned AE = 2;
  localparam int unsigned CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          push = 1'b0;
  logic [W-1:0]  push_data = '0;
  logic          pop = 1'b0;
  logic [W-1:0]  pop_data;
  logic          pop_data_vld_r;
  logic          empty_r;
  logic          full_r;
  logic          afull_r;
  logic          aempty_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;
  logic          underflow_r;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [W-1:0] sb [$];
  int           m_cnt = 0;
  logic         m_ovf = 1'b0;
  logic         m_udf = 1'b0;
  logic         m_vld = 1'b0;
  logic [W-1:0] m_data = '0;

  sfifo #(.W(W), .N(N), .AF_LVL(AF), .AE_LVL(AE)) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .push          (push),
    .push_data     (push_data),
    .pop           (pop),
    .pop_data      (pop_data),
    .pop_data_vld_r(pop_data_vld_r),
    .empty_r       (empty_r),
    .full_r        (full_r),
    .afull_r       (afull_r),
    .aempty_r      (aempty_r),
    .count_r       (count_r),
    .overflow_r    (overflow_r),
    .underflow_r   (underflow_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, update the model, then check all outputs 1 time unit after the edge
  task automatic step(input logic r, input logic c, input logic ps, input logic [W-1:0] d,
                      input logic pp);
    logic pop_acc;
    logic push_acc;
    rst = r; clear = c; push = ps; push_data = d; pop = pp;
    if (r || c) begin
      sb.delete();
      m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0; m_vld = 1'b0;
      if (r) m_data = '0;
    end else begin
      pop_acc  = pp && (m_cnt != 0);
      push_acc = ps && ((m_cnt != N) || pop_acc);
      if (ps && !push_acc) m_ovf = 1'b1;
      if (pp && m_cnt == 0) m_udf = 1'b1;
      if (push_acc) sb.push_back(d);
      m_cnt = m_cnt + int'(push_acc) - int'(pop_acc);
      m_vld = pop_acc;
    end
    @(posedge clk);
    #1;
    rst = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0;
    chk("count", 32'(count_r), 32'(m_cnt));
    chk("empty", 32'(empty_r), 32'(m_cnt == 0));
    chk("full", 32'(full_r), 32'(m_cnt == N));
    chk("afull", 32'(afull_r), 32'(m_cnt >= AF));
    chk("aempty", 32'(aempty_r), 32'(m_cnt <= AE));
    chk("overflow", 32'(overflow_r), 32'(m_ovf));
    chk("underflow", 32'(underflow_r), 32'(m_udf));
    chk("vld", 32'(pop_data_vld_r), 32'(m_vld));
    if (m_vld) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 32'(0), 32'(1));
      end else begin
        m_data = sb.pop_front();
      end
    end
    chk("pop_data", 32'(pop_data), 32'(m_data));
  endtask

  initial begin
    // reset
    step(1, 0, 0, 8'h00, 0);
    chk("rst_aempty", 32'(aempty_r), 32'(1));

    // fill 0x11..0x15, then overflowing push
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'h11 + i), 0);
    step(0, 0, 1, 8'h66, 0);
    chk("ovf_set", 32'(overflow_r), 32'(1));

    // drain, then underflowing pop
    for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1);
    chk("udf_set", 32'(underflow_r), 32'(1));

    // flush clears sticky errors
    step(0, 1, 0, 8'h00, 0);

    // wrap: steady push+pop at count 2
    step(0, 0, 1, 8'hA0, 0);
    step(0, 0, 1, 8'hA1, 0);
    for (int i = 0; i < 32; i++) step(0, 0, 1, 8'(i), 1);
    chk("wrap_count", 32'(count_r), 32'(2));

    // fill to full, then push+pop while full
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'(8'h40 + i), 0);
    step(0, 0, 1, 8'hAA, 1);
    chk("full_sim_full", 32'(full_r), 32'(1));
    chk("full_sim_ovf", 32'(overflow_r), 32'(0));
    for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00, 1);
    chk("aa_last", 32'(pop_data), 32'(8'hAA));

    // push+pop while empty
    step(0, 0, 1, 8'h3C, 1);
    chk("empty_sim_udf", 32'(underflow_r), 32'(1));
    step(0, 0, 0, 8'h00, 1);
    chk("empty_sim_data", 32'(pop_data), 32'(8'h3C));

    // clear together with push/pop at count 3
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'(8'h70 + i), 0);
    step(0, 1, 1, 8'h99, 1);
    chk("clr_count", 32'(count_r), 32'(0));
    chk("clr_data_kept", 32'(pop_data), 32'(8'h3C));

    // mid-stream reset
    step(0, 0, 1, 8'h81, 0);
    step(0, 0, 1, 8'h82, 0);
    step(0, 0, 1, 8'h83, 1);
    step(1, 0, 1, 8'h84, 1);
    chk("rst_data", 32'(pop_data), 32'(0));
    step(0, 0, 1, 8'h55, 0);
    step(0, 0, 0, 8'h00, 1);
    chk("post_rst_data", 32'(pop_data), 32'(8'h55));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
